// File: rtl/host_switch_ctrl.sv
// host_switch_ctrl: owns the CPU A/B host select for the dual-CPU switch board.
// Manual requests via force_swi/cmd_swi; heartbeat-driven failover when the
// SWITCH_AUTO_FAILOVER_EN macro is defined (default build: manual only).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   hb_a, hb_b          async heartbeats, any edge = alive
//   force_swi, cmd_swi  one-cycle manual request and its target (0=A, 1=B)
//   switch              current host (0=A, 1=B)
//   switch_pulse        one-cycle pulse when switch changes
//   alive_a, alive_b    heartbeat status
//   fault               registered, both CPUs dead
//   state               00 HOST_A, 01 HOST_B, 10 HOLD, 11 FAULT
module host_switch_ctrl #(
   parameter int HB_TIMEOUT = 50_000_000,
   parameter int HOLDOFF    = 10_000_000,
   parameter int CNT_W      = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hb_a,
   input  logic       hb_b,
   input  logic       force_swi,
   input  logic       cmd_swi,
   output logic       switch,
   output logic       switch_pulse,
   output logic       alive_a,
   output logic       alive_b,
   output logic       fault,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_HOST_A = 2'b00,
      ST_HOST_B = 2'b01,
      ST_HOLD   = 2'b10,
      ST_FAULT  = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] TO_C   = CNT_W'(HB_TIMEOUT);
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLDOFF);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   // [0],[1] synchroniser, [2] previous value for edge detect
   logic [2:0]       sync_a_q;
   logic [2:0]       sync_b_q;
   logic             edge_a;
   logic             edge_b;
   logic [CNT_W-1:0] cnt_a_q;
   logic [CNT_W-1:0] cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q;
   logic [CNT_W-1:0] cnt_b_d;
   logic             alive_a_w;
   logic             alive_b_w;

   state_e           state_q;
   logic [CNT_W-1:0] hold_q;
   logic             switch_q;
   logic             pulse_q;
   logic             fault_q;

   // ---------------- heartbeat path ----------------
   assign edge_a = sync_a_q[1] ^ sync_a_q[2];
   assign edge_b = sync_b_q[1] ^ sync_b_q[2];

   // An edge wins over saturation: the CPU is kept alive.
   always_comb begin
      cnt_a_d = cnt_a_q;
      if (edge_a) begin
         cnt_a_d = '0;
      end else if (cnt_a_q != TO_C) begin
         cnt_a_d = cnt_a_q + ONE_C;
      end
   end

   always_comb begin
      cnt_b_d = cnt_b_q;
      if (edge_b) begin
         cnt_b_d = '0;
      end else if (cnt_b_q != TO_C) begin
         cnt_b_d = cnt_b_q + ONE_C;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
         cnt_a_q  <= '0;
         cnt_b_q  <= '0;
      end else begin
         sync_a_q <= {sync_a_q[1:0], hb_a};
         sync_b_q <= {sync_b_q[1:0], hb_b};
         cnt_a_q  <= cnt_a_d;
         cnt_b_q  <= cnt_b_d;
      end
   end

   assign alive_a_w = (cnt_a_q != TO_C);
   assign alive_b_w = (cnt_b_q != TO_C);

   // ---------------- host FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HOLD;
         hold_q   <= HOLD_C;
         switch_q <= 1'b0;
         pulse_q  <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         fault_q <= !alive_a_w && !alive_b_w;
         if (force_swi) begin
            // Manual request: always reloads hold-off, even to same host
            switch_q <= cmd_swi;
            pulse_q  <= (cmd_swi != switch_q);
            hold_q   <= HOLD_C;
            state_q  <= ST_HOLD;
         end else begin
            case (state_q)
               ST_HOLD: begin
                  if (hold_q == '0) begin
                     state_q <= switch_q ? ST_HOST_B : ST_HOST_A;
                  end else begin
                     hold_q <= hold_q - ONE_C;
                  end
               end
`ifdef SWITCH_AUTO_FAILOVER_EN
               ST_HOST_A: begin
                  if (!alive_a_w && alive_b_w) begin
                     switch_q <= 1'b1;
                     pulse_q  <= !switch_q;
                     hold_q   <= HOLD_C;
                     state_q  <= ST_HOLD;
                  end else if (!alive_a_w) begin
                     state_q <= ST_FAULT;
                  end
               end
               ST_HOST_B: begin
                  if (!alive_b_w && alive_a_w) begin
                     switch_q <= 1'b0;
                     pulse_q  <= switch_q;
                     hold_q   <= HOLD_C;
                     state_q  <= ST_HOLD;
                  end else if (!alive_b_w) begin
                     state_q <= ST_FAULT;
                  end
               end
               ST_FAULT: begin
                  // A has priority when both recover together
                  if (alive_a_w) begin
                     switch_q <= 1'b0;
                     pulse_q  <= switch_q;
                     hold_q   <= HOLD_C;
                     state_q  <= ST_HOLD;
                  end else if (alive_b_w) begin
                     switch_q <= 1'b1;
                     pulse_q  <= !switch_q;
                     hold_q   <= HOLD_C;
                     state_q  <= ST_HOLD;
                  end
               end
`else
               ST_HOST_A, ST_HOST_B: begin
                  state_q <= state_q;
               end
`endif
               default: begin
                  state_q <= ST_HOLD;
                  hold_q  <= HOLD_C;
               end
            endcase
         end
      end
   end

   assign switch       = switch_q;
   assign switch_pulse = pulse_q;
   assign alive_a      = alive_a_w;
   assign alive_b      = alive_b_w;
   assign fault        = fault_q;
   assign state        = state_q;

endmodule

// File: tb/tb_host_switch_ctrl.sv
// Directed bench for host_switch_ctrl (HB_TIMEOUT=16, HOLDOFF=8).
// Covers both builds, selected by SWITCH_AUTO_FAILOVER_EN.
module tb_host_switch_ctrl;

   localparam int HBT = 16;
   localparam int HO  = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       hb_a = 1'b0;
   logic       hb_b = 1'b0;
   logic       force_swi = 1'b0;
   logic       cmd_swi = 1'b0;
   logic       sw;
   logic       sp;
   logic       al_a;
   logic       al_b;
   logic       flt;
   logic [1:0] st;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_a = 0;
   int last_b = 0;
   bit en_a = 1'b1;
   bit en_b = 1'b1;

   host_switch_ctrl #(
      .HB_TIMEOUT(HBT),
      .HOLDOFF(HO),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .hb_a(hb_a),
      .hb_b(hb_b),
      .force_swi(force_swi),
      .cmd_swi(cmd_swi),
      .switch(sw),
      .switch_pulse(sp),
      .alive_a(al_a),
      .alive_b(al_b),
      .fault(flt),
      .state(st)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Heartbeats toggle every 4 cycles, 2 time units after the edge
   initial forever begin
      repeat (4) @(posedge clk);
      #2;
      if (en_a) begin
         hb_a = ~hb_a;
         last_a = cyc;
      end
      if (en_b) begin
         hb_b = ~hb_b;
         last_b = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      step();
      step();
      total++;
      if (st !== 2'b10 || sw !== 1'b0 || sp !== 1'b0 || flt !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals st=%0d sw=%0b sp=%0b flt=%0b exp 2/0/0/0", st, sw, sp, flt);
      end
      total++;
      if (al_a !== 1'b1 || al_b !== 1'b1) begin
         bad++;
         $display("FAIL reset_alive a=%0b b=%0b exp 1/1", al_a, al_b);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= HO; k++) begin
         step();
         total++;
         if (st !== 2'b10 || sp !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold k=%0d st=%0d sp=%0b exp 2/0", k, st, sp);
         end
      end
      step();
      total++;
      if (st !== 2'b00 || sw !== 1'b0 || sp !== 1'b0 || flt !== 1'b0) begin
         bad++;
         $display("FAIL reset_host_a st=%0d sw=%0b sp=%0b flt=%0b exp 0/0/0/0", st, sw, sp, flt);
      end
   endtask

   task automatic wait_dead_a(input string nm);
      int n = 0;
      en_a = 1'b0;
      while (al_a !== 1'b0 && n < 40) begin
         step();
         n++;
         if (al_a === 1'b1 && sp !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_pre_pulse sp=%0b exp 0", nm, sp);
         end
      end
      total++;
      if (al_a !== 1'b0) begin
         bad++;
         $display("FAIL %s_timeout alive_a=%0b exp 0", nm, al_a);
      end
      total++;
      if (cyc - last_a !== HBT + 3) begin
         bad++;
         $display("FAIL %s_latency got=%0d exp=%0d", nm, cyc - last_a, HBT + 3);
      end
   endtask

`ifdef SWITCH_AUTO_FAILOVER_EN
   task automatic test_failover();
      wait_dead_a("failover");
      step();
      total++;
      if (sw !== 1'b1 || sp !== 1'b1 || st !== 2'b10) begin
         bad++;
         $display("FAIL failover_switch sw=%0b sp=%0b st=%0d exp 1/1/2", sw, sp, st);
      end
      for (int k = 1; k <= HO; k++) begin
         step();
         total++;
         if (st !== 2'b10 || sp !== 1'b0) begin
            bad++;
            $display("FAIL failover_hold k=%0d st=%0d sp=%0b exp 2/0", k, st, sp);
         end
      end
      step();
      total++;
      if (st !== 2'b01 || sw !== 1'b1) begin
         bad++;
         $display("FAIL failover_host_b st=%0d sw=%0b exp 1/1", st, sw);
      end
   endtask

   task automatic test_fault();
      int n = 0;
      en_b = 1'b0;
      while (al_b !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (al_b !== 1'b0 || flt !== 1'b0) begin
         bad++;
         $display("FAIL fault_b_dead alive_b=%0b flt=%0b exp 0/0", al_b, flt);
      end
      step();
      total++;
      if (st !== 2'b11 || flt !== 1'b1 || sw !== 1'b1 || sp !== 1'b0) begin
         bad++;
         $display("FAIL fault_enter st=%0d flt=%0b sw=%0b sp=%0b exp 3/1/1/0", st, flt, sw, sp);
      end
      step();
      step();
      total++;
      if (st !== 2'b11 || sw !== 1'b1) begin
         bad++;
         $display("FAIL fault_stay st=%0d sw=%0b exp 3/1", st, sw);
      end
      en_a = 1'b1;
      n = 0;
      while (sw !== 1'b0 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (sw !== 1'b0 || sp !== 1'b1 || st !== 2'b10 || flt !== 1'b0) begin
         bad++;
         $display("FAIL fault_exit sw=%0b sp=%0b st=%0d flt=%0b exp 0/1/2/0", sw, sp, st, flt);
      end
      total++;
      if (cyc - last_a !== 4) begin
         bad++;
         $display("FAIL fault_exit_latency got=%0d exp=4", cyc - last_a);
      end
      en_b = 1'b1;
      repeat (12) step();
      total++;
      if (st !== 2'b00 || al_b !== 1'b1 || sw !== 1'b0) begin
         bad++;
         $display("FAIL fault_recover st=%0d alive_b=%0b sw=%0b exp 0/1/0", st, al_b, sw);
      end
   endtask

   task automatic test_force_race();
      int pulses = 0;
      wait_dead_a("race");
      force_swi = 1'b1;
      cmd_swi = 1'b1;
      step();
      force_swi = 1'b0;
      en_a = 1'b1;
      total++;
      if (sw !== 1'b1 || sp !== 1'b1 || st !== 2'b10) begin
         bad++;
         $display("FAIL race_switch sw=%0b sp=%0b st=%0d exp 1/1/2", sw, sp, st);
      end
      for (int k = 1; k <= HO; k++) begin
         step();
         if (sp === 1'b1) pulses++;
         total++;
         if (st !== 2'b10) begin
            bad++;
            $display("FAIL race_hold k=%0d st=%0d exp 2", k, st);
         end
      end
      step();
      total++;
      if (st !== 2'b01 || pulses !== 0) begin
         bad++;
         $display("FAIL race_host_b st=%0d extra_pulses=%0d exp 1/0", st, pulses);
      end
      force_swi = 1'b1;
      cmd_swi = 1'b0;
      step();
      force_swi = 1'b0;
      total++;
      if (sw !== 1'b0 || sp !== 1'b1) begin
         bad++;
         $display("FAIL race_back sw=%0b sp=%0b exp 0/1", sw, sp);
      end
      repeat (HO + 1) step();
      total++;
      if (st !== 2'b00) begin
         bad++;
         $display("FAIL race_host_a st=%0d exp 0", st);
      end
   endtask
`else
   task automatic test_no_failover();
      int n = 0;
      int pulses = 0;
      wait_dead_a("nofo");
      repeat (5) begin
         step();
         if (sp !== 1'b0 || sw !== 1'b0) pulses++;
      end
      total++;
      if (pulses !== 0 || st !== 2'b00 || al_a !== 1'b0) begin
         bad++;
         $display("FAIL nofo_stay bad_cycles=%0d st=%0d alive_a=%0b exp 0/0/0", pulses, st, al_a);
      end
      en_b = 1'b0;
      while (al_b !== 1'b0 && n < 40) begin
         step();
         n++;
      end
      total++;
      if (al_b !== 1'b0 || flt !== 1'b0) begin
         bad++;
         $display("FAIL nofo_b_dead alive_b=%0b flt=%0b exp 0/0", al_b, flt);
      end
      step();
      total++;
      if (flt !== 1'b1 || st !== 2'b00 || sw !== 1'b0) begin
         bad++;
         $display("FAIL nofo_fault flt=%0b st=%0d sw=%0b exp 1/0/0", flt, st, sw);
      end
      en_a = 1'b1;
      en_b = 1'b1;
      repeat (10) step();
      total++;
      if (al_a !== 1'b1 || al_b !== 1'b1 || flt !== 1'b0) begin
         bad++;
         $display("FAIL nofo_revive a=%0b b=%0b flt=%0b exp 1/1/0", al_a, al_b, flt);
      end
      force_swi = 1'b1;
      cmd_swi = 1'b1;
      step();
      force_swi = 1'b0;
      total++;
      if (sw !== 1'b1 || sp !== 1'b1 || st !== 2'b10) begin
         bad++;
         $display("FAIL nofo_force_b sw=%0b sp=%0b st=%0d exp 1/1/2", sw, sp, st);
      end
      repeat (HO + 1) step();
      total++;
      if (st !== 2'b01) begin
         bad++;
         $display("FAIL nofo_host_b st=%0d exp 1", st);
      end
      force_swi = 1'b1;
      cmd_swi = 1'b0;
      step();
      force_swi = 1'b0;
      repeat (HO + 1) step();
      total++;
      if (st !== 2'b00 || sw !== 1'b0) begin
         bad++;
         $display("FAIL nofo_host_a st=%0d sw=%0b exp 0/0", st, sw);
      end
   endtask
`endif

   task automatic test_force_same();
      force_swi = 1'b1;
      cmd_swi = 1'b0;
      step();
      force_swi = 1'b0;
      total++;
      if (sp !== 1'b0 || sw !== 1'b0 || st !== 2'b10) begin
         bad++;
         $display("FAIL same_first sp=%0b sw=%0b st=%0d exp 0/0/2", sp, sw, st);
      end
      repeat (4) step();
      force_swi = 1'b1;
      step();
      force_swi = 1'b0;
      total++;
      if (sp !== 1'b0 || st !== 2'b10) begin
         bad++;
         $display("FAIL same_reload sp=%0b st=%0d exp 0/2", sp, st);
      end
      for (int k = 1; k <= HO; k++) begin
         step();
         total++;
         if (st !== 2'b10) begin
            bad++;
            $display("FAIL same_hold k=%0d st=%0d exp 2", k, st);
         end
      end
      step();
      total++;
      if (st !== 2'b00 || sw !== 1'b0) begin
         bad++;
         $display("FAIL same_host_a st=%0d sw=%0b exp 0/0", st, sw);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      en_a = 1'b0;
      en_b = 1'b0;
      while (flt !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      total++;
`ifdef SWITCH_AUTO_FAILOVER_EN
      if (flt !== 1'b1 || st !== 2'b11) begin
         bad++;
         $display("FAIL mid_fault flt=%0b st=%0d exp 1/3", flt, st);
      end
`else
      if (flt !== 1'b1 || st !== 2'b00) begin
         bad++;
         $display("FAIL mid_fault flt=%0b st=%0d exp 1/0", flt, st);
      end
`endif
      force_swi = 1'b1;
      cmd_swi = 1'b1;
      step();
      force_swi = 1'b0;
      total++;
      if (sw !== 1'b1 || sp !== 1'b1 || st !== 2'b10) begin
         bad++;
         $display("FAIL mid_force sw=%0b sp=%0b st=%0d exp 1/1/2", sw, sp, st);
      end
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      total++;
      if (sw !== 1'b0 || sp !== 1'b0 || flt !== 1'b0 || st !== 2'b10) begin
         bad++;
         $display("FAIL mid_reset sw=%0b sp=%0b flt=%0b st=%0d exp 0/0/0/2", sw, sp, flt, st);
      end
      total++;
      if (al_a !== 1'b1 || al_b !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_alive a=%0b b=%0b exp 1/1", al_a, al_b);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
`ifdef SWITCH_AUTO_FAILOVER_EN
      test_failover();
      test_fault();
      test_force_race();
`else
      test_no_failover();
`endif
      test_force_same();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
